// File: rtl/johnson_step_ctrl_if.sv
// Command channel for johnson_step_ctrl: a step request offered over a valid/ready handshake.
// The command source drives the master side; the controller takes the slave side.
interface johnson_step_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_div;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_div,
    output cmd_ready
  );
endinterface

// File: rtl/johnson_step_ctrl.sv
// Johnson phase-register sequencer: issues a commanded number of forward or reverse steps
// at a programmable rate, with preload, hold, abort and illegal-code recovery.
module johnson_step_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  johnson_step_ctrl_if.slave   cmd,
  input  logic                 hold,
  input  logic                 abort,
  input  logic                 pos_load,
  input  logic [WIDTH-1:0]     pos_val,
  output logic [WIDTH-1:0]     q,
  output logic [2*WIDTH-1:0]   phase_oh,
  output logic                 step_pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             legal;
  logic             step_now;
  logic [WIDTH-1:0] q_fwd, q_rev;

  // k-th code of the forward sequence: k ones filling from the LSB, then draining from the LSB.
  function automatic logic [WIDTH-1:0] code_at(input int k);
    logic [WIDTH-1:0] c;
    for (int b = 0; b < WIDTH; b++) begin
      c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
    end
    return c;
  endfunction

  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_phase
    localparam logic [WIDTH-1:0] CODE = code_at(gi);
    assign phase_oh[gi] = (q_q == CODE);
  end

  assign legal = |phase_oh;
  assign q_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign q_rev = {~q_q[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign step_now = (state_q == RUN) && (div_cnt_q == div_q) && !hold && !abort && legal;

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d     = cmd.cmd_dir;
          div_d     = cmd.cmd_div;
          div_cnt_d = '0;
          rem_d     = cmd.cmd_steps;
          if (cmd.cmd_steps == '0) done_d = 1'b1;
          else                     state_d = RUN;
        end
        if (pos_load) q_d = pos_val;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step_now) begin
          q_d       = dir_q ? q_fwd : q_rev;
          div_cnt_d = '0;
          rem_d     = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        // The divider waits out a recovery edge so the step lands right after it.
        end else if (!hold && legal) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
    endcase
    if (!legal) begin
      q_d   = '0;
      err_d = 1'b1;
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q == IDLE);
    busy          = (state_q == RUN);
    step_pulse    = step_now;
    q             = q_q;
    done          = done_q;
    err_illegal   = err_q;
  end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Bench for johnson_step_ctrl: a command table run through a scoreboard, plus short
// sequences for illegal-code recovery, abort in IDLE and reset during RUN.
module tb_johnson_step_ctrl;
  localparam int W     = 4;
  localparam int CW    = 16;
  localparam int DW    = 8;
  localparam int LIMIT = 400;
  localparam int NVEC  = 8;

  typedef struct {
    bit         pl;
    int         pv;
    int         steps;
    bit         dir;
    int         div;
    int         hs;
    int         hl;
    int         ab;
    logic [3:0] eq;
    int         ep;
    int         el;
    bit         ed;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    int         pulses;
    int         lat;
    bit         done;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           hold = 1'b0;
  logic           abort = 1'b0;
  logic           pos_load = 1'b0;
  logic [W-1:0]   pos_val = '0;
  logic [W-1:0]   q;
  logic [2*W-1:0] phase_oh;
  logic           step_pulse, busy, done, err_illegal;

  int   checks = 0;
  int   fails  = 0;
  int   pos_m  = 0;
  logic [3:0] codes [8];
  vec_t tbl [NVEC];
  exp_t sb [$];

  johnson_step_ctrl_if #(.CNT_W(CW), .DIV_W(DW)) cmd_if ();

  johnson_step_ctrl #(.WIDTH(W), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .hold       (hold),
    .abort      (abort),
    .pos_load   (pos_load),
    .pos_val    (pos_val),
    .q          (q),
    .phase_oh   (phase_oh),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input int id, input vec_t v);
    int   cyc, pulses, mi;
    bit   got_done, ended;
    exp_t e;
    sb.push_back('{v.eq, v.ep, v.el, v.ed});
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_steps = CW'(v.steps);
    cmd_if.cmd_dir   = v.dir;
    cmd_if.cmd_div   = DW'(v.div);
    if (v.pl) begin
      pos_load = 1'b1;
      pos_val  = codes[v.pv];
      pos_m    = v.pv;
    end
    mi = pos_m; cyc = 0; pulses = 0; got_done = 1'b0; ended = 1'b0;
    while (!ended && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      cmd_if.cmd_valid = 1'b0;
      pos_load = 1'b0;
      hold  = (cyc >= v.hs) && (cyc < v.hs + v.hl);
      abort = (cyc == v.ab);
      #1;
      check("q_track", q, codes[mi]);
      check("phase_oh", phase_oh, 32'(1) << mi);
      if (done) begin
        got_done = 1'b1;
        ended    = 1'b1;
        check("ready_at_done", cmd_if.cmd_ready, 1);
      end else if (!busy) begin
        ended = 1'b1;
      end else if (step_pulse) begin
        pulses++;
        mi = v.dir ? (mi + 1) % 8 : (mi + 7) % 8;
      end
    end
    hold  = 1'b0;
    abort = 1'b0;
    if (!ended) check("timeout", 1, 0);
    e = sb.pop_front();
    check("final_q", q, e.q);
    check("pulses", pulses, e.pulses);
    check("latency", cyc, e.lat);
    check("done_seen", got_done, e.done);
    pos_m = mi;
    $display("cmd %0d: steps=%0d dir=%0d div=%0d -> q=%b pulses=%0d latency=%0d done=%0d",
             id, v.steps, v.dir, v.div, q, pulses, cyc, got_done);
  endtask

  initial begin
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
    codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;
    //             pl pv st dir div  hs hl ab  eq       ep el   ed
    tbl[0] = '{1'b0, 0, 3, 1'b1, 0,   0, 0, 0, 4'b0111, 3, 4,   1'b1};
    tbl[1] = '{1'b1, 3, 2, 1'b0, 2,   0, 0, 0, 4'b0001, 2, 7,   1'b1};
    tbl[2] = '{1'b1, 0, 9, 1'b1, 0,   0, 0, 0, 4'b0001, 9, 10,  1'b1};
    tbl[3] = '{1'b0, 0, 4, 1'b1, 1,   3, 3, 0, 4'b1110, 4, 12,  1'b1};
    tbl[4] = '{1'b0, 0, 2, 1'b0, 1,   0, 0, 4, 4'b1111, 1, 5,   1'b0};
    tbl[5] = '{1'b0, 0, 0, 1'b1, 3,   0, 0, 0, 4'b1111, 0, 1,   1'b1};
    tbl[6] = '{1'b0, 0, 3, 1'b0, 0,   0, 0, 0, 4'b0001, 3, 4,   1'b1};
    tbl[7] = '{1'b1, 0, 1, 1'b0, 255, 0, 0, 0, 4'b1000, 1, 257, 1'b1};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_steps = '0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_div   = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_illegal, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_phase", phase_oh, 1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_cmd(i, tbl[i]);

    // Illegal code via preload: visible for one cycle, then recovered to 0000.
    @(negedge clk);
    pos_load = 1'b1;
    pos_val  = 4'b0101;
    @(negedge clk);
    pos_load = 1'b0;
    #1;
    check("ill_q", q, 4'b0101);
    check("ill_phase", phase_oh, 0);
    check("ill_err_pre", err_illegal, 0);
    @(negedge clk);
    #1;
    check("ill_fix_q", q, 0);
    check("ill_err", err_illegal, 1);
    check("ill_fix_phase", phase_oh, 1);
    @(negedge clk);
    #1;
    check("ill_err_once", err_illegal, 0);
    $display("seq illegal: q=%b err=%0d", q, err_illegal);

    // Abort while idle has no effect.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("idle_abort_ready", cmd_if.cmd_ready, 1);
    check("idle_abort_q", q, 0);
    $display("seq idle abort: ready=%0d q=%b", cmd_if.cmd_ready, q);

    // Preload ignored in RUN, then asynchronous reset mid-run.
    @(negedge clk);
    pos_load = 1'b1;
    pos_val  = 4'b0001;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_steps = CW'(5);
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_div   = DW'(3);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    pos_load = 1'b0;
    @(negedge clk);
    pos_load = 1'b1;
    pos_val  = 4'b1000;
    @(negedge clk);
    pos_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("run_q_before_rst", q, 4'b0011);
    check("run_busy_before_rst", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_if.cmd_ready, 1);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_done", done, 0);
    $display("seq reset in run: q=%b busy=%0d", q, busy);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
